// File: rtl/tiger_dcache_router.sv
// Routes one core load/store at a time to the data cache picked by the top address bits.
// Cache flushes go to every channel; per-channel stalls are reduced into core-facing stalls.
module tiger_dcache_router #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OUT_W  = ADDR_W + DATA_W + 8,
    parameter int IN_W   = DATA_W + 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_memread,
    input  logic                     core_memwrite,
    input  logic                     core_mem8,
    input  logic                     core_mem16,
    input  logic [ADDR_W-1:0]        core_addr,
    input  logic [DATA_W-1:0]        core_wdata,
    input  logic                     core_flush,
    output logic [DATA_W-1:0]        core_rdata,
    output logic                     core_rdata_valid,
    output logic                     core_dstall,
    output logic                     core_can_flush,
    output logic                     core_stall_cpu,
    output logic                     err_both,
    output logic [NUM_CH*OUT_W-1:0]  aso_TigertoCache_data,
    input  logic [NUM_CH*IN_W-1:0]   asi_CachetoTiger_data
);

    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FL_B    = ADDR_W + DATA_W + 2;
    localparam int CR_B    = DATA_W;
    localparam int CW_B    = DATA_W + 1;
    localparam int CF_B    = DATA_W + 2;
    localparam int SC_B    = DATA_W + 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                m8_q, m8_d;
    logic                m16_q, m16_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CH_BITS-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                valid_q, valid_d;
    logic                canfl_q, canfl_d;
    logic                err_q, err_d;

    logic [CH_BITS-1:0]  sel;
    logic [NUM_CH-1:0]   can_fl_v;
    logic [NUM_CH-1:0]   stall_v;
    logic                sel_can_rd;
    logic                sel_can_wr;
    logic [DATA_W-1:0]   sel_rdata;
    logic [OUT_W-1:0]    req_slice;
    logic                unused_in;

    assign sel = (NUM_CH > 1) ? core_addr[ADDR_W-1 -: CH_BITS] : '0;

    // dStall and the spare top bits of each inbound slice carry nothing we act on
    assign unused_in = ^asi_CachetoTiger_data;

    always_comb begin
        can_fl_v   = '0;
        stall_v    = '0;
        sel_can_rd = 1'b0;
        sel_can_wr = 1'b0;
        sel_rdata  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            can_fl_v[c] = asi_CachetoTiger_data[c*IN_W + CF_B];
            stall_v[c]  = asi_CachetoTiger_data[c*IN_W + SC_B];
            if (sel_q == CH_BITS'(c)) begin
                sel_can_rd = asi_CachetoTiger_data[c*IN_W + CR_B];
                sel_can_wr = asi_CachetoTiger_data[c*IN_W + CW_B];
                sel_rdata  = asi_CachetoTiger_data[c*IN_W +: DATA_W];
            end
        end
    end

    always_comb begin
        req_slice                    = '0;
        req_slice[0]                 = rd_q;
        req_slice[1]                 = wr_q;
        req_slice[ADDR_W+1:2]        = addr_q;
        req_slice[ADDR_W+2 +: DATA_W] = wdata_q;
        req_slice[FL_B+1]            = m8_q;
        req_slice[FL_B+2]            = m16_q;
        aso_TigertoCache_data        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_q == S_REQ && sel_q == CH_BITS'(c)) begin
                aso_TigertoCache_data[c*OUT_W +: OUT_W] = req_slice;
            end
            if (state_q == S_FLUSH) begin
                aso_TigertoCache_data[c*OUT_W + FL_B] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        m8_d    = m8_q;
        m16_d   = m16_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        done_d  = done_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        canfl_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (core_flush) begin
                    state_d = S_FLUSH;
                end else if (core_memread || core_memwrite) begin
                    // a simultaneous read+write is issued as a write
                    rd_d    = core_memread & ~core_memwrite;
                    wr_d    = core_memwrite;
                    m8_d    = core_mem8;
                    m16_d   = core_mem16;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    sel_d   = sel;
                    err_d   = err_q | (core_memread & core_memwrite);
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_q && sel_can_rd) begin
                    rdata_d = sel_rdata;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else if (wr_q && sel_can_wr) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (&(done_q | can_fl_v)) begin
                    done_d  = '0;
                    canfl_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    done_d = done_q | can_fl_v;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            m8_q    <= 1'b0;
            m16_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            canfl_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            m8_q    <= m8_d;
            m16_q   <= m16_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            canfl_q <= canfl_d;
            err_q   <= err_d;
        end
    end

    assign core_rdata       = rdata_q;
    assign core_rdata_valid = valid_q;
    assign core_can_flush   = canfl_q;
    assign err_both         = err_q;
    assign core_stall_cpu   = |stall_v;
    assign core_dstall      = (state_q != S_IDLE) | core_memread
                            | core_memwrite | core_flush;

endmodule

// File: tb/tb_tiger_dcache_router.sv
// Directed bench for tiger_dcache_router: scoreboard of expected load/flush
// responses plus per-cycle conduit checks; second instance with one channel.
module tb_tiger_dcache_router;

    logic         clk = 1'b0;
    logic         reset;
    logic         reset1;
    logic         core_memread, core_memwrite, core_mem8, core_mem16;
    logic [31:0]  core_addr, core_wdata;
    logic         core_flush;
    logic [31:0]  core_rdata;
    logic         core_rdata_valid, core_dstall, core_can_flush;
    logic         core_stall_cpu, err_both;
    logic [143:0] out0;
    logic [79:0]  in0;

    logic [31:0]  rdata1;
    logic         valid1, dstall1, canfl1, stall1, err1;
    logic [71:0]  out1;
    logic [39:0]  in1;

    typedef struct {
        logic        is_flush;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tiger_dcache_router #(.NUM_CH(2)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .core_memread          (core_memread),
        .core_memwrite         (core_memwrite),
        .core_mem8             (core_mem8),
        .core_mem16            (core_mem16),
        .core_addr             (core_addr),
        .core_wdata            (core_wdata),
        .core_flush            (core_flush),
        .core_rdata            (core_rdata),
        .core_rdata_valid      (core_rdata_valid),
        .core_dstall           (core_dstall),
        .core_can_flush        (core_can_flush),
        .core_stall_cpu        (core_stall_cpu),
        .err_both              (err_both),
        .aso_TigertoCache_data (out0),
        .asi_CachetoTiger_data (in0)
    );

    tiger_dcache_router #(.NUM_CH(1)) dut1 (
        .clk                   (clk),
        .reset                 (reset1),
        .core_memread          (core_memread),
        .core_memwrite         (core_memwrite),
        .core_mem8             (core_mem8),
        .core_mem16            (core_mem16),
        .core_addr             (core_addr),
        .core_wdata            (core_wdata),
        .core_flush            (core_flush),
        .core_rdata            (rdata1),
        .core_rdata_valid      (valid1),
        .core_dstall           (dstall1),
        .core_can_flush        (canfl1),
        .core_stall_cpu        (stall1),
        .err_both              (err1),
        .aso_TigertoCache_data (out1),
        .asi_CachetoTiger_data (in1)
    );

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] inb(input logic [31:0] d, input logic crd,
                                        input logic cwr, input logic cfl,
                                        input logic stl);
        logic [39:0] v;
        v = '0;
        v[31:0] = d;
        v[32] = crd;
        v[33] = cwr;
        v[34] = cfl;
        v[36] = stl;
        return v;
    endfunction

    function automatic logic [71:0] req(input logic rd, input logic wr,
                                        input logic [31:0] a,
                                        input logic [31:0] d,
                                        input logic m8, input logic m16);
        logic [71:0] v;
        v = '0;
        v[0] = rd;
        v[1] = wr;
        v[33:2] = a;
        v[65:34] = d;
        v[67] = m8;
        v[68] = m16;
        return v;
    endfunction

    // monitor: every response pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (core_rdata_valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rdata_valid: got data %h want none",
                         core_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_flush || core_rdata !== e.data) begin
                    bad++;
                    $display("FAIL rdata: got %h want %h (flush_exp=%0b)",
                             core_rdata, e.data, e.is_flush);
                end
            end
        end
        if (core_can_flush) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_can_flush: got 1 want 0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (!e.is_flush) begin
                    bad++;
                    $display("FAIL can_flush: got flush want load %h", e.data);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [71:0] fl_slice;

    initial begin
        reset = 1'b1;
        reset1 = 1'b1;
        core_memread = 0; core_memwrite = 0; core_mem8 = 0; core_mem16 = 0;
        core_addr = '0; core_wdata = '0; core_flush = 0;
        in0 = '0; in1 = '0;
        fl_slice = '0;
        fl_slice[66] = 1'b1;

        next(); next();
        @(negedge clk);
        chk("rst_out", out0, '0);
        chk("rst_rdata", core_rdata, '0);
        chk("rst_valid", core_rdata_valid, 0);
        chk("rst_canfl", core_can_flush, 0);
        chk("rst_err", err_both, 0);
        chk("rst_dstall", core_dstall, 0);
        next();
        reset = 1'b0;

        // stall_cpu reduction in IDLE
        in0 = {inb(0, 0, 0, 0, 1), inb(0, 0, 0, 0, 0)};
        @(negedge clk);
        chk("stall_cpu_1", core_stall_cpu, 1);
        next();
        in0 = '0;
        @(negedge clk);
        chk("stall_cpu_0", core_stall_cpu, 0);

        // load on channel 1
        next();
        core_memread = 1; core_addr = 32'h8000_0010;
        @(negedge clk);
        chk("ld_dstall_c0", core_dstall, 1);
        next();
        core_memread = 0; core_addr = '0;
        for (int i = 1; i <= 3; i++) begin
            if (i == 2) in0 = {inb(0, 0, 0, 0, 0), inb(32'h1111, 1, 1, 0, 0)};
            if (i == 3) begin
                in0 = {inb(32'hDEAD_BEEF, 1, 0, 0, 0), inb(0, 0, 0, 0, 0)};
                sb.push_back('{is_flush: 1'b0, data: 32'hDEAD_BEEF});
            end
            @(negedge clk);
            chk("ld_slice1", out0[143:72], req(1, 0, 32'h8000_0010, 0, 0, 0));
            chk("ld_slice0", out0[71:0], '0);
            chk("ld_dstall", core_dstall, 1);
            next();
        end
        in0 = '0;
        @(negedge clk);
        chk("ld_done_out", out0, '0);
        chk("ld_done_dstall", core_dstall, 0);
        next(); next();

        // byte store on channel 0, accept after 5 cycles
        core_memwrite = 1; core_mem8 = 1;
        core_addr = 32'h0000_0040; core_wdata = 32'h1234_5678;
        next();
        core_memwrite = 0; core_mem8 = 0; core_addr = '0; core_wdata = '0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) in0 = {inb(0, 0, 0, 0, 0), inb(0, 0, 1, 0, 0)};
            @(negedge clk);
            chk("st_slice0", out0[71:0],
                req(0, 1, 32'h0000_0040, 32'h1234_5678, 1, 0));
            chk("st_slice1", out0[143:72], '0);
            chk("st_dstall", core_dstall, 1);
            next();
        end
        in0 = '0;
        @(negedge clk);
        chk("st_done_out", out0, '0);
        chk("st_done_dstall", core_dstall, 0);
        next();

        // flush: ch0 done at cycle 2, ch1 at cycle 5
        core_flush = 1;
        @(negedge clk);
        chk("fl_dstall_c0", core_dstall, 1);
        next();
        core_flush = 0;
        for (int i = 1; i <= 5; i++) begin
            in0 = '0;
            if (i == 2) in0 = {inb(0, 0, 0, 0, 0), inb(0, 0, 0, 1, 0)};
            if (i == 5) begin
                in0 = {inb(0, 0, 0, 1, 0), inb(0, 0, 0, 0, 0)};
                sb.push_back('{is_flush: 1'b1, data: 32'h0});
            end
            @(negedge clk);
            chk("fl_slice0", out0[71:0], fl_slice);
            chk("fl_slice1", out0[143:72], fl_slice);
            next();
        end
        in0 = '0;
        @(negedge clk);
        chk("fl_done_out", out0, '0);
        chk("fl_done_dstall", core_dstall, 0);
        next();

        // read+write together: issued as write, sticky error
        core_memread = 1; core_memwrite = 1;
        core_addr = 32'h0000_0100; core_wdata = 32'h0000_A5A5;
        next();
        core_memread = 0; core_memwrite = 0; core_addr = '0; core_wdata = '0;
        in0 = {inb(0, 0, 0, 0, 0), inb(0, 0, 1, 0, 0)};
        @(negedge clk);
        chk("both_slice0", out0[71:0],
            req(0, 1, 32'h0000_0100, 32'h0000_A5A5, 0, 0));
        chk("both_err", err_both, 1);
        next();
        in0 = '0;
        next(); next();
        @(negedge clk);
        chk("both_out_clr", out0, '0);
        chk("both_err_sticky", err_both, 1);

        // reset during a pending load
        next();
        core_memread = 1; core_addr = 32'h0000_0008;
        next();
        core_memread = 0; core_addr = '0;
        @(negedge clk);
        chk("rl_slice0", out0[71:0], req(1, 0, 32'h0000_0008, 0, 0, 0));
        next();
        reset = 1'b1;
        #1;
        chk("rl_out", out0, '0);
        chk("rl_rdata", core_rdata, '0);
        chk("rl_dstall", core_dstall, 0);
        chk("rl_err", err_both, 0);
        next();
        reset = 1'b0;
        in0 = {inb(0, 0, 0, 0, 0), inb(32'h5555_5555, 1, 0, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rl_after_out", out0, '0);
            chk("rl_after_valid", core_rdata_valid, 0);
            next();
        end
        in0 = '0;

        // single-channel instance: top address bits do not steer
        reset1 = 1'b0;
        next();
        core_memread = 1; core_addr = 32'hFFFF_FFFC;
        next();
        core_memread = 0; core_addr = '0;
        in1 = inb(32'hCAFE_F00D, 1, 0, 0, 0);
        @(negedge clk);
        chk("c1_slice", out1, req(1, 0, 32'hFFFF_FFFC, 0, 0, 0));
        next();
        in1 = '0;
        @(negedge clk);
        chk("c1_valid", valid1, 1);
        chk("c1_rdata", rdata1, 32'hCAFE_F00D);
        chk("c1_out_clr", out1, '0);
        next();
        @(negedge clk);
        chk("c1_valid_off", valid1, 0);

        next(); next();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
